seq_char_emitter: RTL and testbench

Stimulus-side counterpart of the `verify` sequence checker. On a `start` request it expands a field-encoded request into the framed ASCII sequence `NUL, prefix, d2, d1, d0, op, L1, L0, NUL`. It presents the sequence one character at a time on an `ascii_char`/`char_valid` strobe interface, paced at the UART receive character rate. Its outputs connect directly to `verify.ascii_char`/`verify.char_valid`, so the checker can be driven in-system without a UART receiver.

---
 rtl/seq_char_emitter.sv | 151 +++++++++++++++
 tb/tb_seq_char_emitter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_char_emitter.sv
// Framed ASCII sequence emitter: NUL, prefix, d2, d1, d0, op, L1, L0, NUL, one char per slot.
// Define SEQ_EMIT_GAP_EN to append a 100-cycle idle gap before done.
module seq_char_emitter #(
    parameter int unsigned UART_RX_BAUD = 20,
    parameter int unsigned freq         = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prefix_sel,
    input  logic [11:0] digits,
    input  logic        op_sel,
    input  logic [15:0] letters,
    output logic [7:0]  ascii_char,
    output logic        char_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TR      = freq / UART_RX_BAUD;
    localparam int unsigned CntW    = (TR > 1) ? $clog2(TR) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TR - 1);

`ifdef SEQ_EMIT_GAP_EN
    localparam logic [6:0] GapLast = 7'd99;
    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
    logic [6:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            done_d;
    logic [7:0]      slot_char;

    logic        prefix_q;
    logic [11:0] digits_q;
    logic        op_q;
    logic [15:0] letters_q;

    function automatic logic [7:0] hex_char(input logic [3:0] code);
        // 0x37 + 10 lands on 'A'
        return (code < 4'd10) ? (8'h30 + {4'h0, code}) : (8'h37 + {4'h0, code});
    endfunction

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SEQ_EMIT_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (idx_q < 4'd8) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        idx_d = 4'd0;
`ifdef SEQ_EMIT_GAP_EN
                        state_d = StGap;
                        gap_d   = '0;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SEQ_EMIT_GAP_EN
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                    gap_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 7'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Slot 0 char is NUL, so the fields are already latched before they are ever selected.
    always_comb begin
        slot_char = 8'h00;
        case (idx_d)
            4'd1:    slot_char = prefix_q ? 8'h40 : 8'h24;
            4'd2:    slot_char = hex_char(digits_q[11:8]);
            4'd3:    slot_char = hex_char(digits_q[7:4]);
            4'd4:    slot_char = hex_char(digits_q[3:0]);
            4'd5:    slot_char = op_q ? 8'h2A : 8'h2B;
            4'd6:    slot_char = letters_q[15:8];
            4'd7:    slot_char = letters_q[7:0];
            default: slot_char = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            ascii_char <= 8'h00;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SEQ_EMIT_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ascii_char <= (state_d == StSend) ? slot_char : 8'h00;
            char_valid <= (state_d == StSend) && (cnt_d == CntLast);
            busy       <= (state_d != StIdle);
            done       <= done_d;
`ifdef SEQ_EMIT_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            prefix_q  <= prefix_sel;
            digits_q  <= digits;
            op_q      <= op_sel;
            letters_q <= letters;
        end
    end

endmodule

// File: tb/tb_seq_char_emitter.sv
// Self-checking bench for seq_char_emitter; expected stream derived from slot timing arithmetic.
module tb_seq_char_emitter;

    localparam int TR = 200 / 20;
`ifdef SEQ_EMIT_GAP_EN
    localparam int Gap = 100;
`else
    localparam int Gap = 0;
`endif
    localparam int Busy = 9 * TR + Gap;

    logic        clk = 1'b0;
    logic        rst, start, prefix_sel, op_sel;
    logic [11:0] digits;
    logic [15:0] letters;
    logic [7:0]  ascii_char;
    logic        char_valid, busy, done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_chars [9];

    always #5 clk = ~clk;

    seq_char_emitter #(.UART_RX_BAUD(20), .freq(200)) dut (
        .clk(clk), .rst(rst), .start(start), .prefix_sel(prefix_sel), .digits(digits),
        .op_sel(op_sel), .letters(letters), .ascii_char(ascii_char), .char_valid(char_valid),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] digit_ascii(input int code);
        return (code < 10) ? 8'(48 + code) : 8'(65 + code - 10);
    endfunction

    // Drive the request fields and record the characters they should produce.
    task automatic set_req(input logic p, input logic [11:0] d, input logic o,
                           input logic [15:0] l);
        prefix_sel = p; digits = d; op_sel = o; letters = l;
        exp_chars[0] = 8'h00;
        exp_chars[1] = p ? 8'h40 : 8'h24;
        exp_chars[2] = digit_ascii(int'(d[11:8]));
        exp_chars[3] = digit_ascii(int'(d[7:4]));
        exp_chars[4] = digit_ascii(int'(d[3:0]));
        exp_chars[5] = o ? 8'h2A : 8'h2B;
        exp_chars[6] = l[15:8];
        exp_chars[7] = l[7:0];
        exp_chars[8] = 8'h00;
    endtask

    // t = cycles since the accepting edge (t=1 is the first busy cycle).
    task automatic check_cycle(input int t);
        logic [7:0] a;
        logic       v;
        a = 8'h00;
        v = 1'b0;
        if (t <= 9 * TR) begin
            a = exp_chars[(t - 1) / TR];
            v = (t % TR) == 0;
        end
        check($sformatf("ascii t=%0d", t), ascii_char, a);
        check($sformatf("valid t=%0d", t), {7'd0, char_valid}, {7'd0, v});
        check($sformatf("busy t=%0d", t), {7'd0, busy}, {7'd0, t <= Busy});
        check($sformatf("done t=%0d", t), {7'd0, done}, {7'd0, t == Busy + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cycle(Busy + 2);
        end
    endtask

    // mode 0: quiet, 1: random input noise while busy, 2: start held high to the end
    task automatic run_seq(input logic p, input logic [11:0] d, input logic o,
                           input logic [15:0] l, input int mode);
        set_req(p, d, o, l);
        start = 1'b1;
        for (int t = 1; t <= Busy + 1; t++) begin
            @(negedge clk);
            check_cycle(t);
            if (t <= Busy && mode == 1) begin
                start      = 1'($urandom);
                prefix_sel = 1'($urandom);
                digits     = 12'($urandom);
                op_sel     = 1'($urandom);
                letters    = 16'($urandom);
            end else begin
                start = (mode == 2);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prefix_sel = 1'b0; digits = '0; op_sel = 1'b0; letters = '0;
        repeat (2) @(negedge clk);
        check_cycle(Busy + 2);
        rst = 1'b0;
        idle(1);

        run_seq(1'b0, 12'h123, 1'b0, "AB", 0);
        idle(1);
        run_seq(1'b1, 12'h456, 1'b1, "XY", 0);
        idle(1);
        run_seq(1'b1, 12'h12A, 1'b0, "BC", 1);
        idle(1);
        // Held start: the next sequence is accepted in the done cycle.
        run_seq(1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom), 2);
        run_seq(1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom), 0);
        idle(1);

        for (int n = 0; n < 3; n++) begin
            run_seq(1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom), 0);
            idle(1 + int'($urandom_range(0, 3)));
        end

        // Reset one cycle after the 4th strobe abandons the sequence.
        set_req(1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom));
        start = 1'b1;
        for (int t = 1; t <= 4 * TR + 1; t++) begin
            @(negedge clk);
            check_cycle(t);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_cycle(Busy + 2);
        rst = 1'b0;
        idle(3 * TR);
        run_seq(1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
